// File: rtl/user_io_fifo_bridge_if.sv
// Fabric-to-user streaming handshake for the user I/O FIFO bridge.
// The slave side is the bridge. The master side is the fabric and user project, or a testbench.
interface user_io_fifo_bridge_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] FIN_DATA;
  logic             FIN_VALID;
  logic             FIN_READY;
  logic [WIDTH-1:0] UOUT_DATA;
  logic             UOUT_VALID;
  logic             UOUT_READY;

  modport slave (
    input  FIN_DATA, FIN_VALID, UOUT_READY,
    output FIN_READY, UOUT_DATA, UOUT_VALID
  );

  modport master (
    output FIN_DATA, FIN_VALID, UOUT_READY,
    input  FIN_READY, UOUT_DATA, UOUT_VALID
  );
endinterface

// File: rtl/user_io_fifo_bridge.sv
// Bridge between the fabric and the user project. A first-word fall-through FIFO carries words
// toward the user project. A 2-flop synchronizer with a change pulse carries the UIN pins back.
module user_io_fifo_bridge #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     UserCLK,
  input  logic                     RESET,
  user_io_fifo_bridge_if.slave     bus,
  input  logic [WIDTH-1:0]         UIN,
  output logic [WIDTH-1:0]         FOUT,
  output logic                     UIN_CHG,
  output logic [$clog2(DEPTH):0]   COUNT
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_push, w_pop, w_not_full, w_not_empty;

  // Both flags depend only on r_count, so there is no combinational path from UOUT_READY to FIN_READY.
  assign w_not_full  = (r_count != L_FULL);
  assign w_not_empty = (r_count != '0);
  assign w_push      = bus.FIN_VALID  & w_not_full;
  assign w_pop       = bus.UOUT_READY & w_not_empty;

  assign bus.FIN_READY  = w_not_full;
  assign bus.UOUT_VALID = w_not_empty;
  assign bus.UOUT_DATA  = r_mem[r_rptr];
  assign COUNT          = r_count;

  always_ff @(posedge UserCLK) begin
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset. Clearing the pointers is enough to discard its contents.
  always_ff @(posedge UserCLK) begin
    if (w_push && !RESET) r_mem[r_wptr] <= bus.FIN_DATA;
  end

  logic [WIDTH-1:0] r_s1, r_s2, r_s3;

  always_ff @(posedge UserCLK) begin
    if (RESET) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= UIN;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign FOUT    = r_s2;
  assign UIN_CHG = (r_s2 != r_s3);
endmodule

// File: tb/tb_user_io_fifo_bridge.sv
// Self-checking bench for user_io_fifo_bridge: table vectors, directed corner cases,
// and random traffic against a queue-based reference model.
module tb_user_io_fifo_bridge;
  localparam int W = 16;
  localparam int D = 4;

  logic          UserCLK = 1'b0;
  logic          RESET;
  logic [W-1:0]  UIN, FOUT;
  logic          UIN_CHG;
  logic [2:0]    COUNT;

  user_io_fifo_bridge_if #(.WIDTH(W)) bus ();

  user_io_fifo_bridge #(.WIDTH(W), .DEPTH(D)) dut (
    .UserCLK (UserCLK),
    .RESET   (RESET),
    .bus     (bus),
    .UIN     (UIN),
    .FOUT    (FOUT),
    .UIN_CHG (UIN_CHG),
    .COUNT   (COUNT)
  );

  always #5 UserCLK = ~UserCLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue, plus the last three UIN samples since reset.
  logic [W-1:0] mq[$];
  logic [W-1:0] hist[$];

  task automatic mstep(input bit rst, input bit fv, input logic [W-1:0] d,
                       input bit ur, input logic [W-1:0] uin);
    bit push, pop;
    logic [W-1:0] efout, eprev;
    RESET = rst; bus.FIN_VALID = fv; bus.FIN_DATA = d; bus.UOUT_READY = ur; UIN = uin;
    push = fv && (mq.size() < D);
    pop  = ur && (mq.size() > 0);
    @(posedge UserCLK); #1;
    if (rst) begin
      mq.delete();
      hist.delete();
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(d);
      hist.push_back(uin);
      if (hist.size() > 3) void'(hist.pop_front());
    end
    efout = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    eprev = (hist.size() >= 3) ? hist[hist.size()-3] : '0;
    chk("m_count", 32'(COUNT), 32'(mq.size()));
    chk("m_fin_ready", 32'(bus.FIN_READY), 32'(mq.size() < D));
    chk("m_uout_valid", 32'(bus.UOUT_VALID), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("m_uout_data", 32'(bus.UOUT_DATA), 32'(mq[0]));
    chk("m_fout", 32'(FOUT), 32'(efout));
    chk("m_uin_chg", 32'(UIN_CHG), 32'(efout != eprev));
  endtask

  typedef struct {
    bit           rst, fv, ur;
    logic [W-1:0] d;
    int           cnt;
    bit           fr, vld;
    logic [W-1:0] dat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit fv, logic [W-1:0] d, bit ur,
                             int cnt, bit fr, bit vld, logic [W-1:0] dat);
    vec_t r;
    r.rst = rst; r.fv = fv; r.d = d; r.ur = ur;
    r.cnt = cnt; r.fr = fr; r.vld = vld; r.dat = dat;
    return r;
  endfunction

  initial begin
    RESET = 1'b1; bus.FIN_VALID = 1'b0; bus.FIN_DATA = '0; bus.UOUT_READY = 1'b0; UIN = '0;

    // Three words in and held at the head, then popped in order.
    tbl.push_back(v(1, 0, 16'h0000, 0, 0, 1, 0, 16'h0000));
    tbl.push_back(v(0, 1, 16'h1111, 0, 1, 1, 1, 16'h1111));
    tbl.push_back(v(0, 1, 16'h2222, 0, 2, 1, 1, 16'h1111));
    tbl.push_back(v(0, 1, 16'h3333, 0, 3, 1, 1, 16'h1111));
    tbl.push_back(v(0, 0, 16'h0000, 0, 3, 1, 1, 16'h1111));
    tbl.push_back(v(0, 0, 16'h0000, 1, 2, 1, 1, 16'h2222));
    tbl.push_back(v(0, 0, 16'h0000, 1, 1, 1, 1, 16'h3333));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 1, 0, 16'h0000));
    // Fill to full. A 5th word is refused, even during a pop, and is taken on the next cycle.
    tbl.push_back(v(0, 1, 16'hA001, 0, 1, 1, 1, 16'hA001));
    tbl.push_back(v(0, 1, 16'hA002, 0, 2, 1, 1, 16'hA001));
    tbl.push_back(v(0, 1, 16'hA003, 0, 3, 1, 1, 16'hA001));
    tbl.push_back(v(0, 1, 16'hA004, 0, 4, 0, 1, 16'hA001));
    tbl.push_back(v(0, 1, 16'hA005, 0, 4, 0, 1, 16'hA001));
    tbl.push_back(v(0, 1, 16'hA005, 1, 3, 1, 1, 16'hA002));
    tbl.push_back(v(0, 1, 16'hA005, 0, 4, 0, 1, 16'hA002));
    tbl.push_back(v(0, 0, 16'h0000, 1, 3, 1, 1, 16'hA003));
    tbl.push_back(v(0, 0, 16'h0000, 1, 2, 1, 1, 16'hA004));
    tbl.push_back(v(0, 0, 16'h0000, 1, 1, 1, 1, 16'hA005));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 1, 0, 16'h0000));
    // Reset at COUNT=3 with a push and pop in the same cycle. The next push must be accepted.
    tbl.push_back(v(0, 1, 16'hB001, 0, 1, 1, 1, 16'hB001));
    tbl.push_back(v(0, 1, 16'hB002, 0, 2, 1, 1, 16'hB001));
    tbl.push_back(v(0, 1, 16'hB003, 0, 3, 1, 1, 16'hB001));
    tbl.push_back(v(1, 1, 16'hB004, 1, 0, 1, 0, 16'h0000));
    tbl.push_back(v(0, 1, 16'hB005, 0, 1, 1, 1, 16'hB005));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 1, 0, 16'h0000));

    foreach (tbl[i]) begin
      RESET = tbl[i].rst; bus.FIN_VALID = tbl[i].fv; bus.FIN_DATA = tbl[i].d;
      bus.UOUT_READY = tbl[i].ur;
      @(posedge UserCLK); #1;
      chk($sformatf("t%0d_count", i), 32'(COUNT), 32'(tbl[i].cnt));
      chk($sformatf("t%0d_fin_ready", i), 32'(bus.FIN_READY), 32'(tbl[i].fr));
      chk($sformatf("t%0d_uout_valid", i), 32'(bus.UOUT_VALID), 32'(tbl[i].vld));
      if (tbl[i].vld) chk($sformatf("t%0d_uout_data", i), 32'(bus.UOUT_DATA), 32'(tbl[i].dat));
      chk($sformatf("t%0d_fout", i), 32'(FOUT), 32'h0);
      chk($sformatf("t%0d_uin_chg", i), 32'(UIN_CHG), 32'h0);
    end

    // Synchronizer: FOUT follows UIN two edges after capture, with exactly one UIN_CHG pulse.
    mstep(1, 0, '0, 0, 16'h0000);
    mstep(0, 0, '0, 0, 16'h0000);
    mstep(0, 0, '0, 0, 16'hA5A5);
    chk("sync_e1_fout", 32'(FOUT), 32'h0);
    chk("sync_e1_chg", 32'(UIN_CHG), 32'h0);
    mstep(0, 0, '0, 0, 16'hA5A5);
    chk("sync_e2_fout", 32'(FOUT), 32'hA5A5);
    chk("sync_e2_chg", 32'(UIN_CHG), 32'h1);
    for (int k = 0; k < 5; k++) begin
      mstep(0, 0, '0, 0, 16'hA5A5);
      chk("sync_static_chg", 32'(UIN_CHG), 32'h0);
    end

    // Run at COUNT=2 with a push and a pop every cycle. Order holds and the pointers wrap.
    mstep(0, 1, 16'hC000, 0, 16'hA5A5);
    mstep(0, 1, 16'hC001, 0, 16'hA5A5);
    for (int k = 0; k < 10; k++) begin
      mstep(0, 1, 16'(16'hC002 + k), 1, 16'hA5A5);
      chk("steady_count2", 32'(COUNT), 32'h2);
    end

    // A push into an empty FIFO is visible on the next cycle. A push and a pop every cycle sustain one word per cycle.
    mstep(1, 0, '0, 0, 16'h0000);
    mstep(0, 1, 16'hD000, 1, 16'h0000);
    chk("lat1_valid", 32'(bus.UOUT_VALID), 32'h1);
    chk("lat1_data", 32'(bus.UOUT_DATA), 32'hD000);
    for (int k = 1; k < 8; k++) begin
      mstep(0, 1, 16'(16'hD000 + k), 1, 16'h0000);
      chk("thru_data", 32'(bus.UOUT_DATA), 32'(16'hD000 + k));
    end

    // Random traffic with UIN changes and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      logic [W-1:0] u;
      u = ($urandom_range(0, 7) == 0) ? W'($urandom) : UIN;
      mstep($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, W'($urandom),
            $urandom_range(0, 2) != 0, u);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/user_io_fifo_bridge.md
USER_IO_FIFO_BRIDGE -- requirements
Module: user_io_fifo_bridge

Interface
REQ-001 Parameter WIDTH SHALL default to 16: data width, matching the 16 user-project I/O lanes.
REQ-002 Parameter DEPTH SHALL default to 4: FIFO entries, power of two, at least 2.
REQ-003 UserCLK  in  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004 RESET  in  1  SHALL be a synchronous, active-high reset.
REQ-005 FIN_DATA  in  WIDTH  SHALL carry the data word from the fabric toward the user project.
REQ-006 FIN_VALID  in  1  SHALL indicate that FIN_DATA is valid.
REQ-007 FIN_READY  out  1  SHALL indicate that the FIFO can accept a word.
REQ-008 UOUT_DATA  out  WIDTH  SHALL present the FIFO head word to the user project.
REQ-009 UOUT_VALID  out  1  SHALL indicate that UOUT_DATA holds a valid word.
REQ-010 UOUT_READY  in  1  SHALL indicate that the user project accepts UOUT_DATA.
REQ-011 UIN  in  WIDTH  SHALL be the user-project input pins, asynchronous to UserCLK.
REQ-012 FOUT  out  WIDTH  SHALL be the synchronized UIN value presented to the fabric.
REQ-013 UIN_CHG  out  1  SHALL pulse for one cycle whenever FOUT changes.
REQ-014 COUNT  out  log2(DEPTH)+1  SHALL report the current FIFO occupancy.

Function
REQ-015 A push SHALL occur in a cycle where FIN_VALID=1 and FIN_READY=1; a pop SHALL occur in a cycle where UOUT_VALID=1 and UOUT_READY=1.
REQ-016 FIN_READY SHALL equal (COUNT < DEPTH), decoded from registered state only; no combinational path from UOUT_READY.
REQ-017 When full, FIN_READY SHALL be 0 even if a pop occurs in the same cycle; no push-through when full.
REQ-018 UOUT_VALID SHALL equal (COUNT != 0); UOUT_DATA SHALL be the storage entry at the read pointer (first-word fall-through).
REQ-019 A word pushed in cycle N SHALL be visible on UOUT_DATA/UOUT_VALID in cycle N+1 when the FIFO was empty; latency is 1 cycle.
REQ-020 COUNT update rules: push only -> +1; pop only -> -1; simultaneous push and pop -> unchanged; neither -> unchanged.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; order SHALL be strict FIFO with no loss or duplication.
REQ-022 UOUT_DATA and UOUT_VALID SHALL remain stable while UOUT_VALID=1 and UOUT_READY=0.
REQ-023 FIN_VALID while FIN_READY=0 SHALL be ignored, with no state change; UOUT_READY while UOUT_VALID=0 SHALL be ignored.
REQ-024 UIN SHALL pass through a 2-flop synchronizer (s1, s2); FOUT SHALL be s2, so an input change reaches FOUT 2 cycles after the first capturing edge.
REQ-025 A third register s3 SHALL hold the previous FOUT; UIN_CHG SHALL equal (s2 != s3), producing exactly one high cycle per FOUT change.
REQ-026 The synchronizer path and the FIFO path SHALL be independent; activity on either SHALL not affect the other.

Reset
REQ-027 While RESET=1 at a clock edge: pointers, COUNT, s1, s2 and s3 SHALL clear to 0, giving UOUT_VALID=0, FIN_READY=1, FOUT=0 and UIN_CHG=0 from the next cycle.
REQ-028 Reset asserted mid-transfer SHALL discard all FIFO contents, and any push or pop in the reset cycle SHALL have no effect; storage contents need not be cleared.
REQ-029 The first push SHALL be accepted in the first cycle after RESET deasserts.

Verification
REQ-030 Reset, then push 0x1111, 0x2222, 0x3333 with UOUT_READY=0 -> COUNT=3, UOUT_DATA=0x1111 held stable; set UOUT_READY=1 -> words pop in order over 3 cycles, then COUNT=0.
REQ-031 Push 4 words with UOUT_READY=0 -> FIN_READY=0 at COUNT=4; a 5th word with FIN_VALID held is not taken; pop 1 -> FIN_READY=1 the next cycle, and the 5th word is accepted then.
REQ-032 With COUNT=2, run simultaneous push and pop for 10 cycles -> COUNT stays 2, output order matches input order, pointers wrap cleanly.
REQ-033 Push into an empty FIFO at cycle N -> UOUT_VALID=1 with correct data at N+1; push and pop every cycle -> sustained throughput of 1 word/cycle.
REQ-034 UIN changes 0x0000 -> 0xA5A5 -> FOUT=0xA5A5 two edges later, UIN_CHG=1 for exactly that one cycle; holding UIN static -> UIN_CHG stays 0.
REQ-035 Assert RESET with COUNT=3 -> next cycle COUNT=0, UOUT_VALID=0, FIN_READY=1, FOUT=0; a push in the first post-reset cycle is accepted.
